segre_mem_arbiter: RTL and testbench

SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

---
 rtl/segre_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_segre_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// Memory arbiter shared by the icache and dcache: requests are queued in one FIFO
// and issued to memory one at a time, with completions routed back to the owner.
package segre_mem_arbiter_pkg;
    localparam int CACHE_LINE_SIZE_BITS = 128;
    localparam int ARB_BUF_SIZE = 16;
    localparam int ARB_PTR_SIZE = $clog2(ARB_BUF_SIZE);

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } cache_id_e;

    typedef struct packed {
        cache_id_e                       cache_id;
        logic                            rd_wr;
        logic [31:0]                     addr;
        logic [CACHE_LINE_SIZE_BITS-1:0] data;
    } cache_mem_req_t;
endpackage

module segre_mem_arbiter
    import segre_mem_arbiter_pkg::*;
#(
    parameter int BUF_SIZE = ARB_BUF_SIZE
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ic_req_valid_i,
    input  cache_mem_req_t                  ic_req_i,
    output logic                            ic_req_ready_o,
    input  logic                            dc_req_valid_i,
    input  cache_mem_req_t                  dc_req_i,
    output logic                            dc_req_ready_o,
    output logic                            mem_req_valid_o,
    output cache_mem_req_t                  mem_req_o,
    input  logic                            mem_req_ready_i,
    input  logic                            mem_rsp_valid_i,
    input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
    output logic                            ic_rsp_valid_o,
    output logic                            dc_rsp_valid_o,
    output logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o
);
    localparam int PTR_W = $clog2(BUF_SIZE);
    localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(BUF_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e           state;
    cache_mem_req_t   fifo [BUF_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             dc_push;
    logic             ic_push;
    logic             pop;

    // Readiness looks only at the registered count; a same-cycle pop frees nothing yet.
    assign dc_req_ready_o = (count < DEPTH);
    assign dc_push        = dc_req_valid_i & dc_req_ready_o;
    assign ic_req_ready_o = ((count + (PTR_W+1)'(dc_push)) < DEPTH);
    assign ic_push        = ic_req_valid_i & ic_req_ready_o;
    assign pop            = (state == WAIT) & mem_rsp_valid_i;

    // Storage needs no reset: the pointers and count define which entries are live.
    // The dcache entry takes the lower slot when both caches push together.
    always_ff @(posedge clk_i) begin
        if (dc_push)
            fifo[wr_ptr] <= dc_req_i;
        if (ic_push)
            fifo[wr_ptr + PTR_W'(dc_push)] <= ic_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(dc_push) + PTR_W'(ic_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (PTR_W+1)'(dc_push) + (PTR_W+1)'(ic_push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            mem_req_valid_o <= 1'b0;
            mem_req_o       <= '0;
            ic_rsp_valid_o  <= 1'b0;
            dc_rsp_valid_o  <= 1'b0;
            rsp_line_o      <= '0;
        end else begin
            ic_rsp_valid_o <= 1'b0;
            dc_rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state           <= ISSUE;
                        mem_req_valid_o <= 1'b1;
                        mem_req_o       <= fifo[rd_ptr];
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        state           <= WAIT;
                        mem_req_valid_o <= 1'b0;
                    end
                end
                WAIT: begin
                    // mem_req_o still holds the head entry, so it names the owner.
                    if (mem_rsp_valid_i) begin
                        state          <= IDLE;
                        rsp_line_o     <= mem_rsp_line_i;
                        ic_rsp_valid_o <= (mem_req_o.cache_id == ICACHE);
                        dc_rsp_valid_o <= (mem_req_o.cache_id == DCACHE);
                    end
                end
                default: begin
                    state           <= IDLE;
                    mem_req_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed vector table, hand sequences for the
// fill/stall/reset corners, and a randomized run against a queue-based model.
module tb_segre_mem_arbiter;
    import segre_mem_arbiter_pkg::*;

    localparam logic [CACHE_LINE_SIZE_BITS-1:0] LINE_A5 = {16{8'hA5}};

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            ic_req_valid;
    cache_mem_req_t                  ic_req;
    logic                            ic_req_ready;
    logic                            dc_req_valid;
    cache_mem_req_t                  dc_req;
    logic                            dc_req_ready;
    logic                            mem_req_valid;
    cache_mem_req_t                  mem_req;
    logic                            mem_req_ready;
    logic                            mem_rsp_valid;
    logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line;
    logic                            ic_rsp_valid;
    logic                            dc_rsp_valid;
    logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    segre_mem_arbiter #(.BUF_SIZE(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ic_req_valid_i (ic_req_valid),
        .ic_req_i       (ic_req),
        .ic_req_ready_o (ic_req_ready),
        .dc_req_valid_i (dc_req_valid),
        .dc_req_i       (dc_req),
        .dc_req_ready_o (dc_req_ready),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_o      (mem_req),
        .mem_req_ready_i(mem_req_ready),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_line_i (mem_rsp_line),
        .ic_rsp_valid_o (ic_rsp_valid),
        .dc_rsp_valid_o (dc_rsp_valid),
        .rsp_line_o     (rsp_line)
    );

    typedef struct {
        logic        icv;
        logic [31:0] ica;
        logic        dcv;
        logic [31:0] dca;
        logic        mrdy;
        logic        rspv;
        logic        emv;
        logic [31:0] ema;
        logic        eicp;
        logic        edcp;
    } vec_t;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic cache_mem_req_t mk(input cache_id_e id, input logic wr, input logic [31:0] addr);
        cache_mem_req_t r;
        r          = '0;
        r.cache_id = id;
        r.rd_wr    = wr;
        r.addr     = addr;
        r.data     = {4{addr}};
        return r;
    endfunction

    function automatic vec_t v(input logic icv, input logic [31:0] ica, input logic dcv,
                               input logic [31:0] dca, input logic mrdy, input logic rspv,
                               input logic emv, input logic [31:0] ema, input logic eicp,
                               input logic edcp);
        vec_t x;
        x = '{icv, ica, dcv, dca, mrdy, rspv, emv, ema, eicp, edcp};
        return x;
    endfunction

    task automatic quiet();
        ic_req_valid  = 1'b0;
        dc_req_valid  = 1'b0;
        ic_req        = '0;
        dc_req        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_line  = LINE_A5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mem_req_valid"}, 128'(mem_req_valid), 128'(0));
        check({tag, " mem_req"}, 128'(mem_req.addr), 128'(0));
        check({tag, " ic_rsp_valid"}, 128'(ic_rsp_valid), 128'(0));
        check({tag, " dc_rsp_valid"}, 128'(dc_rsp_valid), 128'(0));
        check({tag, " rsp_line"}, rsp_line, 128'(0));
        check({tag, " ic_req_ready"}, 128'(ic_req_ready), 128'(1));
        check({tag, " dc_req_ready"}, 128'(dc_req_ready), 128'(1));
    endtask

    // Reference model state: pending requests in arrival order plus where the head is.
    cache_mem_req_t                  mq[$];
    logic                            m_issuing;
    logic                            m_outst;
    logic                            m_icp;
    logic                            m_dcp;
    logic [CACHE_LINE_SIZE_BITS-1:0] m_line;

    initial begin
        vec_t tbl[17];
        tbl[0]  = v(1, 32'h100, 0, 0,       1, 0, 0, 0,       0, 0);
        tbl[1]  = v(0, 0,       0, 0,       1, 0, 0, 0,       0, 0);
        tbl[2]  = v(0, 0,       0, 0,       1, 0, 1, 32'h100, 0, 0);
        tbl[3]  = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 0);
        tbl[4]  = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 0);
        tbl[5]  = v(0, 0,       0, 0,       0, 1, 0, 0,       0, 0);
        tbl[6]  = v(0, 0,       0, 0,       0, 0, 0, 0,       1, 0);
        tbl[7]  = v(1, 32'h200, 1, 32'h300, 0, 0, 0, 0,       0, 0);
        tbl[8]  = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 0);
        tbl[9]  = v(0, 0,       0, 0,       1, 0, 1, 32'h300, 0, 0);
        tbl[10] = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 0);
        tbl[11] = v(0, 0,       0, 0,       0, 1, 0, 0,       0, 0);
        tbl[12] = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 1);
        tbl[13] = v(0, 0,       0, 0,       1, 0, 1, 32'h200, 0, 0);
        tbl[14] = v(0, 0,       0, 0,       0, 1, 0, 0,       0, 0);
        tbl[15] = v(0, 0,       0, 0,       0, 0, 0, 0,       1, 0);
        tbl[16] = v(0, 0,       0, 0,       0, 0, 0, 0,       0, 0);

        // Reset state
        do_reset();
        @(negedge clk);
        check_reset_vals("reset");
        tick();

        // Single read, then simultaneous ic/dc requests
        foreach (tbl[i]) begin
            quiet();
            ic_req_valid  = tbl[i].icv;
            ic_req        = mk(ICACHE, 1'b0, tbl[i].ica);
            dc_req_valid  = tbl[i].dcv;
            dc_req        = mk(DCACHE, 1'b0, tbl[i].dca);
            mem_req_ready = tbl[i].mrdy;
            mem_rsp_valid = tbl[i].rspv;
            @(negedge clk);
            check($sformatf("tbl%0d mem_req_valid", i), 128'(mem_req_valid), 128'(tbl[i].emv));
            if (tbl[i].emv)
                check($sformatf("tbl%0d mem_req.addr", i), 128'(mem_req.addr), 128'(tbl[i].ema));
            check($sformatf("tbl%0d ic_rsp_valid", i), 128'(ic_rsp_valid), 128'(tbl[i].eicp));
            check($sformatf("tbl%0d dc_rsp_valid", i), 128'(dc_rsp_valid), 128'(tbl[i].edcp));
            if (tbl[i].eicp || tbl[i].edcp)
                check($sformatf("tbl%0d rsp_line", i), rsp_line, LINE_A5);
            tick();
        end

        // Reset while a transaction is outstanding with three entries queued
        quiet();
        mem_req_ready = 1'b1;
        ic_req_valid = 1'b1;  ic_req = mk(ICACHE, 1'b0, 32'h400);
        dc_req_valid = 1'b1;  dc_req = mk(DCACHE, 1'b1, 32'h500);
        tick();
        quiet();
        mem_req_ready = 1'b1;
        dc_req_valid = 1'b1;  dc_req = mk(DCACHE, 1'b0, 32'h600);
        tick();
        quiet();
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("rstwait issue valid", 128'(mem_req_valid), 128'(1));
        check("rstwait issue addr", 128'(mem_req.addr), 128'(32'h500));
        tick();
        quiet();
        rst = 1'b1;
        #1;
        check_reset_vals("rstwait");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rsp_valid = (k < 2);
            @(negedge clk);
            check($sformatf("rstwait late%0d ic_rsp", k), 128'(ic_rsp_valid), 128'(0));
            check($sformatf("rstwait late%0d dc_rsp", k), 128'(dc_rsp_valid), 128'(0));
            check($sformatf("rstwait late%0d mem_valid", k), 128'(mem_req_valid), 128'(0));
            tick();
        end

        // Fill with 16 dcache writes while memory stalls
        do_reset();
        for (int i = 0; i < 16; i++) begin
            quiet();
            dc_req_valid = 1'b1;
            dc_req       = mk(DCACHE, 1'b1, 32'h1000 + 32'(i * 16));
            @(negedge clk);
            check($sformatf("fill%0d dc_ready", i), 128'(dc_req_ready), 128'(1));
            if (i >= 2 && i <= 6) begin
                check($sformatf("stall%0d valid", i), 128'(mem_req_valid), 128'(1));
                check($sformatf("stall%0d addr", i), 128'(mem_req.addr), 128'(32'h1000));
            end
            tick();
        end
        quiet();
        ic_req_valid = 1'b1;  ic_req = mk(ICACHE, 1'b0, 32'h3000);
        dc_req_valid = 1'b1;  dc_req = mk(DCACHE, 1'b0, 32'h2000);
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("full dc_ready", 128'(dc_req_ready), 128'(0));
        check("full ic_ready", 128'(ic_req_ready), 128'(0));
        tick();
        quiet();
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        check("full wait valid", 128'(mem_req_valid), 128'(0));
        check("full pop still no credit", 128'(dc_req_ready), 128'(0));
        tick();
        quiet();
        ic_req_valid = 1'b1;  ic_req = mk(ICACHE, 1'b0, 32'h3000);
        dc_req_valid = 1'b1;  dc_req = mk(DCACHE, 1'b0, 32'h2000);
        @(negedge clk);
        check("cnt15 dc_ready", 128'(dc_req_ready), 128'(1));
        check("cnt15 ic_ready", 128'(ic_req_ready), 128'(0));
        check("cnt15 dc_rsp pulse", 128'(dc_rsp_valid), 128'(1));
        tick();
        quiet();
        @(negedge clk);
        check("cnt16 dc_ready", 128'(dc_req_ready), 128'(0));
        check("cnt16 next head valid", 128'(mem_req_valid), 128'(1));
        check("cnt16 next head addr", 128'(mem_req.addr), 128'(32'h1010));
        tick();

        // Randomized run against the queue model
        do_reset();
        mq.delete();
        m_issuing = 1'b0;
        m_outst   = 1'b0;
        m_icp     = 1'b0;
        m_dcp     = 1'b0;
        m_line    = '0;
        for (int c = 0; c < 3000; c++) begin
            quiet();
            ic_req_valid  = ($urandom_range(99) < 40);
            dc_req_valid  = ($urandom_range(99) < 40);
            ic_req        = mk(ICACHE, 1'($urandom), $urandom);
            dc_req        = mk(DCACHE, 1'($urandom), $urandom);
            mem_req_ready = ($urandom_range(99) < 50);
            mem_rsp_valid = ($urandom_range(99) < 30);
            mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                mq.delete();
                m_issuing = 1'b0;
                m_outst   = 1'b0;
                m_icp     = 1'b0;
                m_dcp     = 1'b0;
                @(negedge clk);
                check("rnd reset mem_valid", 128'(mem_req_valid), 128'(0));
                check("rnd reset pulses", 128'({ic_rsp_valid, dc_rsp_valid}), 128'(0));
                tick();
                rst = 1'b0;
            end else begin
                logic dcp, icp, pop, exp_dcr, exp_icr;
                int   sz;
                sz      = mq.size();
                exp_dcr = (sz < 16);
                dcp     = dc_req_valid && exp_dcr;
                exp_icr = (sz + int'(dcp) < 16);
                icp     = ic_req_valid && exp_icr;
                @(negedge clk);
                check("rnd dc_ready", 128'(dc_req_ready), 128'(exp_dcr));
                check("rnd ic_ready", 128'(ic_req_ready), 128'(exp_icr));
                check("rnd mem_valid", 128'(mem_req_valid), 128'(m_issuing));
                if (m_issuing)
                    check("rnd mem_req", 128'({mem_req.cache_id, mem_req.rd_wr, mem_req.addr}),
                          128'({mq[0].cache_id, mq[0].rd_wr, mq[0].addr}));
                check("rnd ic_rsp", 128'(ic_rsp_valid), 128'(m_icp));
                check("rnd dc_rsp", 128'(dc_rsp_valid), 128'(m_dcp));
                if (m_icp || m_dcp)
                    check("rnd rsp_line", rsp_line, m_line);
                pop   = m_outst && mem_rsp_valid;
                m_icp = pop && (mq[0].cache_id == ICACHE);
                m_dcp = pop && (mq[0].cache_id == DCACHE);
                if (pop) m_line = mem_rsp_line;
                if (m_issuing) begin
                    if (mem_req_ready) begin
                        m_issuing = 1'b0;
                        m_outst   = 1'b1;
                    end
                end else if (!m_outst && sz > 0) begin
                    m_issuing = 1'b1;
                end
                if (pop) begin
                    m_outst = 1'b0;
                    void'(mq.pop_front());
                end
                if (dcp) mq.push_back(dc_req);
                if (icp) mq.push_back(ic_req);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
